multiplexeur_rr_n: RTL
======================

// Module: multiplexeur_rr_n
// PURPOSE
//  Parametrised, registered N-to-1 multiplexer carrying WIDTH-bit packets with valid/ready handshakes.
//  It is the clocked successor of the combinational fixed-select muxes in routing/.
//  Runtime mode selects either round-robin arbitration among requesters or a fixed, externally selected channel.
//  Packets (beats terminated by last) are never interleaved.
//  Sits between several producers and one shared consumer link.
// PARAMETERS
//  WIDTH   8                  data bits per beat
//  NB_IN   4                  number of input channels, >= 2
//  SEL_W   $clog2(NB_IN)      width of channel index (derived, do not override)
// PORTS
//  clk        in   1              single clock, all state on rising edge
//  reset      in   1              asynchronous, active-high reset
//  mode       in   1              0 = round-robin arbitration, 1 = fixed select
//  sel_fixe   in   SEL_W          channel used when mode=1
//  in_data    in   NB_IN*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   NB_IN          per-channel beat valid
//  in_last    in   NB_IN          per-channel last beat of packet
//  in_ready   out  NB_IN          per-channel beat accepted when valid&ready
//  out_data   out  WIDTH          registered output beat
//  out_valid  out  1              output beat valid
//  out_last   out  1              output beat is last of packet
//  out_src    out  SEL_W          index of channel that produced out_data
//  out_ready  in   1              consumer accepts beat when out_valid&out_ready
// BEHAVIOUR
//  - Reset (async, active-high):
//    - state=IDLE, grant=0, rr_ptr=0.
//    - out_valid=0, out_data=0, out_last=0, out_src=0, in_ready=0.
//  - FSM, two states:
//    - IDLE: evaluated every cycle; mode and sel_fixe are sampled only here.
//      - mode=0: grant = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NB_IN.
//      - mode=1: grant = sel_fixe, only if in_valid[sel_fixe]=1. Out-of-range sel_fixe (>= NB_IN) never grants.
//      - On a grant: register grant, go to LOCK next cycle. Arbitration costs exactly 1 cycle; in_ready=0 in IDLE.
//    - LOCK: in_ready[grant] = !out_valid | out_ready. All other in_ready bits are 0.
//      - An accepted beat loads out_data/out_last/out_src (out_src=grant) and sets out_valid next cycle.
//      - Accepted beat with in_last=1: go to IDLE; rr_ptr = (grant+1) mod NB_IN, wrapping NB_IN-1 -> 0.
//      - In mode 1, rr_ptr is still updated, so a return to mode 0 stays fair.
//      - mode/sel_fixe changes during LOCK are ignored until IDLE.
//  - Output register:
//    - out_valid clears when out_valid&out_ready and no new beat is accepted the same cycle.
//    - Simultaneous drain + accept: register reloads and out_valid stays 1, giving 1 beat/cycle throughput.
//    - Holds data stable while out_valid&!out_ready (no change, no drop).
//  - Latency: beat accepted in cycle t appears on out_* at t+1. First beat of a packet needs 1 extra cycle for arbitration.
//  - Packet gap: after last is accepted, at least 1 idle input cycle (IDLE arbitration) before the next packet's first beat.
//  - in_valid dropping mid-packet in LOCK: no beat transfers; lock is held until last arrives.
//  - Reset mid-packet: packet truncated, output beat discarded, no recovery.
// STRUCTURE
//  - Shared header multiplexeur_defs.vh holds:
//    - state encodings ST_IDLE=1'b0, ST_LOCK=1'b1;
//    - mode encodings MODE_RR=1'b0, MODE_FIXE=1'b1.
//  - One sub-module: arbitre_rr_n (NB_IN param).
//    - Inputs: req[NB_IN], rr_ptr[SEL_W].
//    - Outputs: gnt_idx[SEL_W], gnt_ok.
//    - Purely combinational rotate/priority-encode/rotate-back.
//  - Top holds FSM, grant/rr_ptr registers, output register, data select.
// TESTING
//  - Reset: assert reset mid-traffic -> all outputs 0 within the same cycle; state IDLE; rr_ptr=0 after release.
//  - RR fairness, NB_IN=4:
//    - Stimulus: all channels hold valid with 1-beat packets, out_ready=1.
//    - Required: out_src sequence 0,1,2,3,0 and beat data matches each source.
//  - Packet lock:
//    - Stimulus: ch1 sends 3 beats (last on 3rd) while ch2 is valid throughout.
//    - Required: 3 ch1 beats contiguous on out_*, then ch2; in_ready[2]=0 until ch1's last is accepted.
//  - Fixed mode:
//    - Stimulus: mode=1, sel_fixe=2, all valid.
//    - Required: only out_src=2.
//    - Stimulus: sel_fixe changed to 0 mid-packet.
//    - Required: switch occurs only after ch2's last.
//  - Backpressure:
//    - Stimulus: out_ready=0 for 5 cycles with out_valid=1.
//    - Required: out_data stable, in_ready[grant]=0; on out_ready=1, beats resume with none lost or duplicated.
//  - Wrap and out-of-range:
//    - Stimulus: rr_ptr=3, only ch0 valid.
//    - Required: grant 0, rr_ptr becomes 1.
//    - Stimulus: NB_IN=3, mode=1, sel_fixe=3.
//    - Required: no grant, in_ready=0.

Source files
------------

// File: rtl/multiplexeur_rr_n_pkg.sv
// Shared encodings for the registered round-robin packet multiplexer.
// Holds FSM state and mode constants plus a modulo-increment helper.
package multiplexeur_rr_n_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCK   = 1'b1;

    localparam logic       MODE_RR   = 1'b0;
    localparam logic       MODE_FIXE = 1'b1;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/arbitre_rr_n.sv
// Combinational round-robin arbiter: rotate requests by the pointer,
// pick the lowest set bit, then rotate the index back.
module arbitre_rr_n
    import multiplexeur_rr_n_pkg::*;
#(
    parameter int NB_IN = 4,
    parameter int SEL_W = $clog2(NB_IN)
) (
    input  logic [NB_IN-1:0] req,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_ok
);

    localparam logic [SEL_W:0] NB_W = (SEL_W+1)'(NB_IN);

    logic [2*NB_IN-1:0] dbl;
    logic [NB_IN-1:0]   rot;
    logic [SEL_W-1:0]   pos;
    logic [SEL_W:0]     sum;

    always_comb begin
        // bit i of rot is req[(i + rr_ptr) mod NB_IN]
        dbl    = {req, req} >> rr_ptr;
        rot    = dbl[NB_IN-1:0];
        gnt_ok = 1'b0;
        pos    = '0;
        for (int i = 0; i < NB_IN; i++) begin
            if (!gnt_ok && rot[i]) begin
                gnt_ok = 1'b1;
                pos    = SEL_W'(i);
            end
        end
        sum = {1'b0, pos} + {1'b0, rr_ptr};
        if (sum >= NB_W) begin
            sum = sum - NB_W;
        end
        gnt_idx = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/multiplexeur_rr_n.sv
// Registered N-to-1 packet mux: round-robin or fixed channel selection,
// packets never interleaved, one-beat output register with full throughput.
module multiplexeur_rr_n
    import multiplexeur_rr_n_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NB_IN = 4,
    parameter int SEL_W = $clog2(NB_IN)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel_fixe,
    input  logic [NB_IN*WIDTH-1:0] in_data,
    input  logic [NB_IN-1:0]       in_valid,
    input  logic [NB_IN-1:0]       in_last,
    output logic [NB_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    output logic                   out_last,
    output logic [SEL_W-1:0]       out_src,
    input  logic                   out_ready
);

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [SEL_W-1:0] src_q, src_d;

    logic [SEL_W-1:0] arb_idx;
    logic             arb_ok;
    logic             fix_ok;
    logic [WIDTH-1:0] sel_data;
    logic             sel_valid;
    logic             sel_last;
    logic             take;
    logic             accept;

    arbitre_rr_n #(
        .NB_IN (NB_IN)
    ) u_arb (
        .req     (in_valid),
        .rr_ptr  (rr_ptr_q),
        .gnt_idx (arb_idx),
        .gnt_ok  (arb_ok)
    );

    // Out-of-range sel_fixe matches no channel, so it never grants.
    always_comb begin
        fix_ok    = 1'b0;
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NB_IN; i++) begin
            if (sel_fixe == SEL_W'(i)) begin
                fix_ok = in_valid[i];
            end
            if (grant_q == SEL_W'(i)) begin
                sel_data  = in_data[i*WIDTH +: WIDTH];
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
            end
        end
    end

    assign take   = !valid_q || out_ready;
    assign accept = (state_q == ST_LOCK) && sel_valid && take;

    always_comb begin
        in_ready = '0;
        if (state_q == ST_LOCK) begin
            for (int i = 0; i < NB_IN; i++) begin
                if (grant_q == SEL_W'(i)) begin
                    in_ready[i] = take;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mode == MODE_RR) begin
                    if (arb_ok) begin
                        grant_d = arb_idx;
                        state_d = ST_LOCK;
                    end
                end else if (fix_ok) begin
                    grant_d = sel_fixe;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (accept && sel_last) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = SEL_W'(wrap_inc(int'(grant_q), NB_IN));
                end
            end
        endcase
    end

    // Drain and reload in the same cycle keeps valid high.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        src_d   = src_q;
        if (accept) begin
            data_d  = sel_data;
            last_d  = sel_last;
            src_d   = grant_q;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            src_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            src_q    <= src_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_src   = src_q;

endmodule
